// File: rtl/riscv_pkg.sv
// Shared writeback-stage types and constants: result-select encoding and datapath sizes.
package riscv_pkg;
    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;
    localparam int CNT_W  = 64;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_UIMM = 2'b11
    } resultsrc_e;

    function automatic logic [XLEN-1:0] wb_select(
        input resultsrc_e       src,
        input logic [XLEN-1:0]  alu,
        input logic [XLEN-1:0]  mem,
        input logic [XLEN-1:0]  pc4,
        input logic [XLEN-1:0]  uimm
    );
        logic [XLEN-1:0] res;
        res = alu;
        case (src)
            RES_ALU:  res = alu;
            RES_MEM:  res = mem;
            RES_PC4:  res = pc4;
            RES_UIMM: res = uimm;
            default:  res = alu;
        endcase
        return res;
    endfunction
endpackage

// File: rtl/riscv_wb_stage_if.sv
// Writeback-stage bus: MW-stage results and decode read ports in, read data and hazard info out.
interface riscv_wb_stage_if
    import riscv_pkg::*;
#(
    parameter int W   = XLEN,
    parameter int CW  = CNT_W
) ();
    logic          i_riscv_wb_valid;
    logic [W-1:0]  i_riscv_wb_pcplus4;
    logic [W-1:0]  i_riscv_wb_aluresult;
    logic [W-1:0]  i_riscv_wb_uimm;
    logic [W-1:0]  i_riscv_wb_memload;
    logic [63:0]   i_riscv_wb_rdaddr;
    logic [1:0]    i_riscv_wb_resultsrc;
    logic          i_riscv_wb_regw;
    logic [4:0]    i_riscv_wb_rs1addr;
    logic [4:0]    i_riscv_wb_rs2addr;
    logic [W-1:0]  o_riscv_wb_rs1data;
    logic [W-1:0]  o_riscv_wb_rs2data;
    logic [W-1:0]  o_riscv_wb_result;
    logic [4:0]    o_riscv_wb_rdaddr;
    logic          o_riscv_wb_regw;
    logic [CW-1:0] o_riscv_wb_retire_cnt;

    modport master (
        output i_riscv_wb_valid, i_riscv_wb_pcplus4, i_riscv_wb_aluresult, i_riscv_wb_uimm,
               i_riscv_wb_memload, i_riscv_wb_rdaddr, i_riscv_wb_resultsrc, i_riscv_wb_regw,
               i_riscv_wb_rs1addr, i_riscv_wb_rs2addr,
        input  o_riscv_wb_rs1data, o_riscv_wb_rs2data, o_riscv_wb_result, o_riscv_wb_rdaddr,
               o_riscv_wb_regw, o_riscv_wb_retire_cnt
    );

    modport slave (
        input  i_riscv_wb_valid, i_riscv_wb_pcplus4, i_riscv_wb_aluresult, i_riscv_wb_uimm,
               i_riscv_wb_memload, i_riscv_wb_rdaddr, i_riscv_wb_resultsrc, i_riscv_wb_regw,
               i_riscv_wb_rs1addr, i_riscv_wb_rs2addr,
        output o_riscv_wb_rs1data, o_riscv_wb_rs2data, o_riscv_wb_result, o_riscv_wb_rdaddr,
               o_riscv_wb_regw, o_riscv_wb_retire_cnt
    );
endinterface

// File: rtl/riscv_regfile.sv
// Integer register file: one write port, two combinational read ports with write-through bypass.
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int NR = NREGS,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2
);
    logic [W-1:0] regs [NR];

    assign regs[0] = '0;

    // x0 has no storage; every other register owns its own write-enabled flop row.
    for (genvar g = 1; g < NR; g++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                regs[g] <= '0;
            else if (we && wa == AW'(g))
                regs[g] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == '0)
            rd1 = '0;
        else if (we && ra1 == wa)
            rd1 = wd;
    end

    always_comb begin
        rd2 = regs[ra2];
        if (ra2 == '0)
            rd2 = '0;
        else if (we && ra2 == wa)
            rd2 = wd;
    end
endmodule

// File: rtl/riscv_wb_stage.sv
// Writeback stage: result mux, write-enable generation and register file.
// Optional retired-instruction counter enabled by RISCV_WB_RETIRE_CNT_EN.
module riscv_wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input logic              i_riscv_mw_clk,
    input logic              i_riscv_mw_rst,
    riscv_wb_stage_if.slave  bus
);
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   result;
    logic              we;

    // Upper rdaddr bits are don't-care; only the architectural index matters.
    assign rd     = bus.i_riscv_wb_rdaddr[REG_AW-1:0];
    assign result = wb_select(resultsrc_e'(bus.i_riscv_wb_resultsrc), bus.i_riscv_wb_aluresult,
                              bus.i_riscv_wb_memload, bus.i_riscv_wb_pcplus4, bus.i_riscv_wb_uimm);
    assign we     = bus.i_riscv_wb_valid & bus.i_riscv_wb_regw & (rd != '0);

    assign bus.o_riscv_wb_result = result;
    assign bus.o_riscv_wb_rdaddr = rd;
    assign bus.o_riscv_wb_regw   = we;

    riscv_regfile #(
        .W  (XLEN),
        .NR (NREGS),
        .AW (REG_AW)
    ) u_regfile (
        .clk (i_riscv_mw_clk),
        .rst (i_riscv_mw_rst),
        .we  (we),
        .wa  (rd),
        .wd  (result),
        .ra1 (bus.i_riscv_wb_rs1addr),
        .ra2 (bus.i_riscv_wb_rs2addr),
        .rd1 (bus.o_riscv_wb_rs1data),
        .rd2 (bus.o_riscv_wb_rs2data)
    );

`ifdef RISCV_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt;

    // Counts every real instruction leaving WB, whether or not it writes a register.
    always_ff @(posedge i_riscv_mw_clk or posedge i_riscv_mw_rst) begin
        if (i_riscv_mw_rst)
            retire_cnt <= '0;
        else if (bus.i_riscv_wb_valid)
            retire_cnt <= retire_cnt + 1'b1;
    end

    assign bus.o_riscv_wb_retire_cnt = retire_cnt;
`else
    assign bus.o_riscv_wb_retire_cnt = '0;
`endif
endmodule

// File: tb/tb_riscv_wb_stage.sv
// Self-checking bench for riscv_wb_stage: directed tables and sequences plus a randomized model run.
module tb_riscv_wb_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    riscv_wb_stage_if bus ();

    riscv_wb_stage dut (
        .i_riscv_mw_clk (clk),
        .i_riscv_mw_rst (rst),
        .bus            (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  src;
        logic [63:0] exp;
    } mux_vec_t;

    mux_vec_t mv [4];

    logic [63:0] mreg [32];
    logic [63:0] mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [63:0] rda, input logic [1:0] src,
                         input logic [63:0] alu, input logic [63:0] mem, input logic [63:0] pc4,
                         input logic [63:0] uimm, input logic [4:0] r1, input logic [4:0] r2);
        bus.i_riscv_wb_valid     = v;
        bus.i_riscv_wb_regw      = rw;
        bus.i_riscv_wb_rdaddr    = rda;
        bus.i_riscv_wb_resultsrc = src;
        bus.i_riscv_wb_aluresult = alu;
        bus.i_riscv_wb_memload   = mem;
        bus.i_riscv_wb_pcplus4   = pc4;
        bus.i_riscv_wb_uimm      = uimm;
        bus.i_riscv_wb_rs1addr   = r1;
        bus.i_riscv_wb_rs2addr   = r2;
    endtask

    initial begin
        logic [63:0] exp_res, exp1, exp2, rda;
        logic        exp_we, v, rw;
        logic [1:0]  src;
        logic [4:0]  r1, r2, rdi;
        logic [63:0] a, m, p, u;

        mv[0] = '{2'd0, 64'h11};
        mv[1] = '{2'd1, 64'h22};
        mv[2] = '{2'd2, 64'h33};
        mv[3] = '{2'd3, 64'h44};

        // Power-on reset state
        drive(0, 0, 64'd0, 2'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd1, 5'd2);
        #2;
        chk("reset_result", bus.o_riscv_wb_result, 64'd0);
        chk("reset_regw", {63'd0, bus.o_riscv_wb_regw}, 64'd0);
        chk("reset_rs1", bus.o_riscv_wb_rs1data, 64'd0);
        chk("reset_cnt", bus.o_riscv_wb_retire_cnt, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Result mux sweep, bubble so nothing is written
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 64'd9, mv[i].src, 64'h11, 64'h22, 64'h33, 64'h44, 5'd0, 5'd0);
            #1;
            chk($sformatf("mux_src%0d", i), bus.o_riscv_wb_result, mv[i].exp);
            chk($sformatf("mux_regw%0d", i), {63'd0, bus.o_riscv_wb_regw}, 64'd0);
        end

        // Write with same-cycle bypass on both ports, then stored value
        @(negedge clk);
        drive(1, 1, 64'd5, 2'd0, 64'hDEAD, 64'd0, 64'd0, 64'd0, 5'd5, 5'd5);
        #1;
        chk("byp_rs1", bus.o_riscv_wb_rs1data, 64'hDEAD);
        chk("byp_rs2", bus.o_riscv_wb_rs2data, 64'hDEAD);
        chk("byp_regw", {63'd0, bus.o_riscv_wb_regw}, 64'd1);
        chk("byp_rdaddr", {59'd0, bus.o_riscv_wb_rdaddr}, 64'd5);
        @(negedge clk);
        drive(1, 0, 64'd5, 2'd0, 64'hBEEF, 64'd0, 64'd0, 64'd0, 5'd5, 5'd0);
        #1;
        chk("stored_r5", bus.o_riscv_wb_rs1data, 64'hDEAD);
        chk("stored_regw", {63'd0, bus.o_riscv_wb_regw}, 64'd0);

        // x0 is never written and never bypassed
        @(negedge clk);
        drive(1, 1, 64'd0, 2'd3, 64'd0, 64'd0, 64'd0, 64'hFFFF, 5'd0, 5'd0);
        #1;
        chk("x0_regw", {63'd0, bus.o_riscv_wb_regw}, 64'd0);
        chk("x0_rs1", bus.o_riscv_wb_rs1data, 64'd0);
        chk("x0_result", bus.o_riscv_wb_result, 64'hFFFF);
        @(negedge clk);
        drive(0, 0, 64'd0, 2'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0);
        #1;
        chk("x0_after", bus.o_riscv_wb_rs1data, 64'd0);

        // Bubble with regw=1 must not write or bypass
        @(negedge clk);
        drive(1, 1, 64'd7, 2'd0, 64'h77, 64'd0, 64'd0, 64'd0, 5'd7, 5'd0);
        @(negedge clk);
        drive(0, 1, 64'd7, 2'd0, 64'hBAD, 64'd0, 64'd0, 64'd0, 5'd7, 5'd0);
        #1;
        chk("bubble_regw", {63'd0, bus.o_riscv_wb_regw}, 64'd0);
        chk("bubble_nobyp", bus.o_riscv_wb_rs1data, 64'h77);
        @(negedge clk);
        drive(0, 0, 64'd0, 2'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd7, 5'd0);
        #1;
        chk("bubble_r7", bus.o_riscv_wb_rs1data, 64'h77);

        // Upper rdaddr bits ignored
        @(negedge clk);
        drive(1, 1, 64'h1_0000_0003, 2'd0, 64'h333, 64'd0, 64'd0, 64'd0, 5'd0, 5'd3);
        #1;
        chk("wide_rd_regw", {63'd0, bus.o_riscv_wb_regw}, 64'd1);
        chk("wide_rd_addr", {59'd0, bus.o_riscv_wb_rdaddr}, 64'd3);
        @(negedge clk);
        drive(0, 0, 64'd0, 2'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd3);
        #1;
        chk("wide_rd_r3", bus.o_riscv_wb_rs2data, 64'h333);

        // Retire counter wrap, or tied-off port
`ifdef RISCV_WB_RETIRE_CNT_EN
        @(negedge clk);
        force dut.retire_cnt = '1;
        #1;
        release dut.retire_cnt;
        chk("cnt_forced", bus.o_riscv_wb_retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.i_riscv_wb_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_riscv_wb_valid = 1'b0;
        chk("cnt_wrap", bus.o_riscv_wb_retire_cnt, 64'd0);
`else
        chk("cnt_tied", bus.o_riscv_wb_retire_cnt, 64'd0);
`endif

        // Reset asserted mid-cycle clears everything at once
        @(negedge clk);
        drive(0, 0, 64'd0, 2'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd5, 5'd7);
        #1;
        chk("pre_reset_r5", bus.o_riscv_wb_rs1data, 64'hDEAD);
        #2;
        rst = 1'b1;
        #1;
        chk("async_r5", bus.o_riscv_wb_rs1data, 64'd0);
        for (int i = 0; i < 32; i++) begin
            bus.i_riscv_wb_rs1addr = 5'(i);
            bus.i_riscv_wb_rs2addr = 5'(31 - i);
            #1;
            chk($sformatf("rst_rs1_x%0d", i), bus.o_riscv_wb_rs1data, 64'd0);
            chk($sformatf("rst_rs2_x%0d", 31 - i), bus.o_riscv_wb_rs2data, 64'd0);
        end
        chk("rst_cnt", bus.o_riscv_wb_retire_cnt, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against a spec-level model
        for (int i = 0; i < 32; i++) mreg[i] = 64'd0;
        mcnt = 64'd0;
        for (int n = 0; n < 400; n++) begin
            v   = 1'($urandom_range(0, 3) != 0);
            rw  = 1'($urandom_range(0, 3) != 0);
            rda = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) rda[63:5] = '0;
            src = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom}; m = {$urandom, $urandom};
            p = {$urandom, $urandom}; u = {$urandom, $urandom};
            rdi = rda[4:0];
            r1 = ($urandom_range(0, 2) == 0) ? rdi : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? rdi : 5'($urandom_range(0, 31));
            drive(v, rw, rda, src, a, m, p, u, r1, r2);

            exp_res = (src == 2'd0) ? a : (src == 2'd1) ? m : (src == 2'd2) ? p : u;
            exp_we  = v && rw && rdi != 0;
            exp1 = (r1 == 0) ? 64'd0 : (exp_we && r1 == rdi) ? exp_res : mreg[r1];
            exp2 = (r2 == 0) ? 64'd0 : (exp_we && r2 == rdi) ? exp_res : mreg[r2];
            #1;
            chk("rnd_result", bus.o_riscv_wb_result, exp_res);
            chk("rnd_regw", {63'd0, bus.o_riscv_wb_regw}, {63'd0, exp_we});
            chk("rnd_rdaddr", {59'd0, bus.o_riscv_wb_rdaddr}, {59'd0, rdi});
            chk("rnd_rs1", bus.o_riscv_wb_rs1data, exp1);
            chk("rnd_rs2", bus.o_riscv_wb_rs2data, exp2);
`ifdef RISCV_WB_RETIRE_CNT_EN
            chk("rnd_cnt", bus.o_riscv_wb_retire_cnt, mcnt);
`else
            chk("rnd_cnt", bus.o_riscv_wb_retire_cnt, 64'd0);
`endif
            @(posedge clk);
            if (exp_we) mreg[rdi] = exp_res;
            if (v) mcnt = mcnt + 64'd1;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
